// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and write enables for a shared instruction/data memory.
module multicycle_controller #(
    parameter bit SUPPORT_JAL   = 1'b1,
    parameter bit SUPPORT_ITYPE = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_update;
        logic       branch;
        logic       illegal;
    } moore_t;

    // Outputs are registered from the next state, so they line up with r_state.
    function automatic moore_t decode_state(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            S_FETCH: begin
                m.alu_src_b  = 2'b10;
                m.result_src = 2'b10;
            end
            S_DECODE: begin
                m.alu_src_a = 2'b01;
                m.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                m.alu_src_a = 2'b10;
                m.alu_src_b = 2'b01;
            end
            S_MEMREAD: m.adr_src = 1'b1;
            S_MEMWB: begin
                m.result_src = 2'b01;
                m.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                m.adr_src   = 1'b1;
                m.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                m.alu_src_a = 2'b10;
                m.alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                m.alu_src_a = 2'b10;
                m.alu_src_b = 2'b01;
                m.alu_op    = 2'b10;
            end
            S_ALUWB: m.reg_write = 1'b1;
            S_JAL: begin
                m.alu_src_a = 2'b01;
                m.alu_src_b = 2'b10;
                m.pc_update = 1'b1;
            end
            S_BEQ: begin
                m.alu_src_a = 2'b10;
                m.alu_op    = 2'b01;
                m.branch    = 1'b1;
            end
            S_TRAP: m.illegal = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    state_t r_state;
    moore_t r_out;
    state_t w_next;
    logic   w_rdy;
    logic   w_fetch_go;

    assign w_rdy      = mem_ready | ~MEM_HANDSHAKE;
    assign w_fetch_go = rst_n & (r_state == S_FETCH) & w_rdy;

    always_comb begin
        w_next = S_TRAP;
        case (r_state)
            S_FETCH:    w_next = w_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_LOAD || op == OP_STORE) w_next = S_MEMADR;
                else if (op == OP_RTYPE)              w_next = S_EXECUTER;
                else if (op == OP_ITYPE && SUPPORT_ITYPE) w_next = S_EXECUTEI;
                else if (op == OP_JAL && SUPPORT_JAL) w_next = S_JAL;
                else if (op == OP_BEQ)                w_next = S_BEQ;
                else                                  w_next = S_TRAP;
            end
            S_MEMADR:   w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = w_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = w_rdy ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_BEQ:      w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_out   <= decode_state(S_FETCH);
        end else begin
            r_state <= w_next;
            r_out   <= decode_state(w_next);
        end
    end

    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_STORE: imm_src = 2'b01;
            OP_BEQ:   imm_src = 2'b10;
            OP_JAL:   imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    // rst_n gating keeps the handshake/branch-dependent enables quiet during reset.
    assign ir_write   = w_fetch_go;
    assign pc_write   = w_fetch_go | (rst_n & (r_out.pc_update | (r_out.branch & zero)));
    assign adr_src    = r_out.adr_src;
    assign mem_write  = r_out.mem_write;
    assign reg_write  = r_out.reg_write;
    assign result_src = r_out.result_src;
    assign alu_src_a  = r_out.alu_src_a;
    assign alu_src_b  = r_out.alu_src_b;
    assign alu_op     = r_out.alu_op;
    assign illegal    = r_out.illegal;
    assign state      = r_state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle main decoder.
- Sequences each RV32I instruction through a Moore FSM: fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and write enables for a shared instruction/data memory.
- Adds a memory ready handshake, optional opcode support and an illegal-opcode trap.

Parameters:
- SUPPORT_JAL, 1: 1 decodes jal (1101111); 0 sends it to TRAP.
- SUPPORT_ITYPE, 1: 1 decodes I-type ALU (0010011); 0 sends it to TRAP.
- MEM_HANDSHAKE, 1: 1 stalls on mem_ready; 0 ignores mem_ready and treats it as 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  opcode field of the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
- ir_write  out  1  instruction register enable.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write enable.
- result_src  out  2  result select: 00 = ALU out register, 01 = data register, 10 = ALU result.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- alu_op  out  2  ALU operation class: 00 = add, 01 = subtract/branch, 10 = funct-decoded.
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- illegal  out  1  sticky trap flag.
- state  out  4  current state, for debug.

Behaviour:
- Reset:
  - While rst_n is low, the state is FETCH (0) and illegal is 0.
  - pc_write, ir_write, mem_write and reg_write are forced to 0.
  - Select outputs take their FETCH values.
- Outputs are Moore, decoded from state only. Exceptions: ir_write/pc_write in FETCH use mem_ready, and pc_write in BEQ uses zero. Any field not listed for a state is 0.
- imm_src is combinational from op: 0000011 and 0010011 give 00; 0100011 gives 01; 1100011 gives 10; 1101111 gives 11; any other opcode gives 00.
- pc_write = pc_update | (branch & zero).
- Per-state outputs and transitions:
  - FETCH (0): adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write=pc_update=rdy, where rdy = mem_ready or MEM_HANDSHAKE==0. Holds in FETCH until rdy, then goes to DECODE.
  - DECODE (1): a=01, b=01, alu_op=00. Next state by op:
    - 0000011 or 0100011: MEMADR.
    - 0110011: EXECUTER.
    - 0010011 with SUPPORT_ITYPE: EXECUTEI.
    - 1101111 with SUPPORT_JAL: JAL.
    - 1100011: BEQ.
    - anything else: TRAP.
  - MEMADR (2): a=10, b=01, alu_op=00. Goes to MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD (3): adr_src=1, result_src=00. Holds until rdy, then goes to MEMWB.
  - MEMWB (4): result_src=01, reg_write=1. Goes to FETCH.
  - MEMWRITE (5): adr_src=1, result_src=00, mem_write=1. mem_write stays asserted every cycle until rdy; then goes to FETCH.
  - EXECUTER (6): a=10, b=00, alu_op=10. Goes to ALUWB.
  - EXECUTEI (8): a=10, b=01, alu_op=10. Goes to ALUWB.
  - ALUWB (7): result_src=00, reg_write=1. Goes to FETCH.
  - JAL (9): a=01, b=10, alu_op=00, result_src=00, pc_update=1. Goes to ALUWB.
  - BEQ (10): a=10, b=00, alu_op=01, result_src=00, branch=1. Goes to FETCH.
  - TRAP (11): all enables 0 and illegal=1. Stays in TRAP until reset.
  - Unused encodings 12–15: go to TRAP on the next clock.
- Cycle counts (with mem_ready high): load 5, store 4, R-type 4, I-type 4, jal 4, beq 3.
- A reset asserted mid-instruction aborts it immediately; no further write enable is issued.

Test Plan:
- lw (op=0000011), mem_ready=1: states 0,1,2,3,4,0. reg_write=1 only in state 4, with result_src=01.
- sw (op=0100011), mem_ready low for 2 cycles in MEMWRITE: mem_write=1 for 3 consecutive cycles, then the FSM returns to FETCH.
- beq with zero=1: pc_write=1 in state 10. beq with zero=0: pc_write=0. Both return to FETCH after 3 cycles.
- jal, SUPPORT_JAL=1: states 0,1,9,7. pc_write=1 and imm_src=11 in state 9.
- op=1111111: TRAP, illegal=1 and held. With SUPPORT_JAL=0, jal also traps. Deasserting rst_n clears illegal and returns to FETCH.
- rst_n pulsed low during MEMREAD: state=0 asynchronously and all enables 0. MEM_HANDSHAKE=0 with mem_ready=0 gives no stall.
